load_store_unit: RTL and testbench

- Sits between the MEM pipeline stage and data_memory. Accepts byte-addressed load/store requests through a valid/ready handshake.
- Drives the word-addressed, single-port data memory, whose reads are combinational and whose writes are level-sensitive on WNR.
- Handles byte and halfword access with big-endian lane selection, sign/zero extension of loads, and read-modify-write sequencing for sub-word stores.
- Returns a one-cycle response pulse carrying the load data or completion status.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for the word-addressed data_memory: big-endian lanes,
// load extension, read-modify-write for SB/SH. Optional macro: LSU_ALIGN_CHECK_EN.
module load_store_unit #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W+1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              rsp_valid,
   output logic [WIDTH-1:0]  rsp_rdata,
   output logic              rsp_err,
   output logic              mem_wnr,
   output logic [ADDR_W-1:0] mem_address,
   output logic [WIDTH-1:0]  mem_in,
   input  logic [WIDTH-1:0]  mem_out
);

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_LBU = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [WIDTH-1:0]    wdata_q, merge_q, merge_d, rdata_q, load_ext;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic                misalign;
   logic                accept;

   assign accept = (state_q == S_IDLE) && req_valid;

`ifdef LSU_ALIGN_CHECK_EN
   logic err_q;
   assign misalign = (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0]) ||
                     (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));
   assign rsp_err  = err_q & rsp_valid;
`else
   assign misalign = 1'b0;
   assign rsp_err  = 1'b0;
`endif

   assign rsp_rdata = rdata_q;

   // Lane select and merge; halfwords use addr[1] only, so addr[0] is ignored there.
   always_comb begin
      byte_sel = mem_out[31:24];
      case (addr_q[1:0])
         2'd0: byte_sel = mem_out[31:24];
         2'd1: byte_sel = mem_out[23:16];
         2'd2: byte_sel = mem_out[15:8];
         2'd3: byte_sel = mem_out[7:0];
         default: byte_sel = mem_out[31:24];
      endcase
      half_sel = addr_q[1] ? mem_out[15:0] : mem_out[31:16];

      case (op_q)
         OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_ext = {24'd0, byte_sel};
         OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_ext = {16'd0, half_sel};
         default: load_ext = mem_out;
      endcase

      merge_d = mem_out;
      if (op_q == OP_SB) begin
         case (addr_q[1:0])
            2'd0: merge_d[31:24] = wdata_q[7:0];
            2'd1: merge_d[23:16] = wdata_q[7:0];
            2'd2: merge_d[15:8]  = wdata_q[7:0];
            2'd3: merge_d[7:0]   = wdata_q[7:0];
            default: merge_d = mem_out;
         endcase
      end else if (op_q == OP_SH) begin
         if (addr_q[1]) merge_d[15:0]  = wdata_q[15:0];
         else           merge_d[31:16] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      mem_wnr     = 1'b0;
      mem_address = '0;
      mem_in      = '0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (misalign)                                 state_d = S_RESP;
               else if (req_op == OP_SW)                     state_d = S_WR;
               else if ((req_op == OP_SB) || (req_op == OP_SH)) state_d = S_RMW_RD;
               else                                          state_d = S_RD;
            end
         end
         S_RD: begin
            mem_address = addr_q[ADDR_W+1:2];
            state_d     = S_RESP;
         end
         S_RMW_RD: begin
            mem_address = addr_q[ADDR_W+1:2];
            state_d     = S_WR;
         end
         S_WR: begin
            mem_wnr     = !rst;
            mem_address = addr_q[ADDR_W+1:2];
            mem_in      = (op_q == OP_SW) ? wdata_q : merge_q;
            state_d     = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= misalign;
`endif
         end
         if (state_q == S_RD)     rdata_q <= load_ext;
         if (state_q == S_RMW_RD) merge_q <= merge_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a simple word memory model.
// Expectations for the misaligned case follow LSU_ALIGN_CHECK_EN.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_wnr;
   logic [7:0]  mem_address;
   logic [31:0] mem_in;
   logic [31:0] mem_out;
   logic [31:0] mem [0:255];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.WIDTH(32), .ADDR_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_wnr(mem_wnr), .mem_address(mem_address), .mem_in(mem_in), .mem_out(mem_out)
   );

   assign mem_out = mem[mem_address];
   always @(posedge clk) if (mem_wnr) mem[mem_address] <= mem_in;

   // Drives one request and measures cycles from the accept edge to rsp_valid.
   task automatic issue(input logic [2:0] op, input logic [9:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er, output int wcnt);
      int w;
      @(negedge clk);
      req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 10) begin @(negedge clk); w++; end
      @(posedge clk); #1 req_valid = 1'b0;
      lat = -1; rd = 'x; er = 1'bx; wcnt = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (mem_wnr) wcnt++;
         if (rsp_valid) begin lat = i; rd = rsp_rdata; er = rsp_err; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
      total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
      total++; if (mem_wnr !== 1'b0) begin bad++; $display("FAIL rst_wnr got=%b exp=0", mem_wnr); end
      total++; if (mem_address !== 8'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_address); end
      total++; if (mem_in !== 32'h0) begin bad++; $display("FAIL rst_mem_in got=%h exp=0", mem_in); end
      rst = 1'b0;
   endtask

   task automatic test_lw_round_trip();
      int lat, wc; logic [31:0] rd; logic er;
      issue(3'd7, 10'h010, 32'hDEADBEEF, lat, rd, er, wc);
      total++; if (lat !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", lat); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL sw_rdata got=%h exp=0", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL sw_err got=%b exp=0", er); end
      total++; if (wc !== 1) begin bad++; $display("FAIL sw_write_cycles got=%0d exp=1", wc); end
      total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
      issue(3'd2, 10'h010, 32'h0, lat, rd, er, wc);
      total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
      total++; if (wc !== 0) begin bad++; $display("FAIL lw_write_cycles got=%0d exp=0", wc); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  ops  [5] = '{3'd0, 3'd3, 3'd0, 3'd1, 3'd4};
      logic [9:0]  adrs [5] = '{10'h010, 10'h010, 10'h012, 10'h010, 10'h012};
      logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01};
      int lat, wc; logic [31:0] rd; logic er;
      issue(3'd7, 10'h010, 32'h80FF7F01, lat, rd, er, wc);
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], adrs[i], 32'h0, lat, rd, er, wc);
         total++;
         if (rd !== exps[i] || lat !== 2) begin
            bad++; $display("FAIL load_ext[%0d] got=%h lat=%0d exp=%h lat=2", i, rd, lat, exps[i]);
         end
      end
   endtask

   task automatic test_rmw();
      int lat, wc; logic [31:0] rd; logic er;
      issue(3'd7, 10'h010, 32'h11223344, lat, rd, er, wc);
      issue(3'd5, 10'h013, 32'h555555AA, lat, rd, er, wc);
      total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency got=%0d exp=3", lat); end
      total++; if (wc !== 1) begin bad++; $display("FAIL sb_write_cycles got=%0d exp=1", wc); end
      total++; if (mem[4] !== 32'h112233AA) begin bad++; $display("FAIL sb_mem got=%h exp=112233aa", mem[4]); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL sb_rdata got=%h exp=0", rd); end
      issue(3'd6, 10'h010, 32'h1234BEEF, lat, rd, er, wc);
      total++; if (lat !== 3) begin bad++; $display("FAIL sh_latency got=%0d exp=3", lat); end
      total++; if (mem[4] !== 32'hBEEF33AA) begin bad++; $display("FAIL sh_mem got=%h exp=beef33aa", mem[4]); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ops  [3] = '{3'd2, 3'd5, 3'd2};
      logic [9:0]  adrs [3] = '{10'h010, 10'h011, 10'h010};
      logic [31:0] wds  [3] = '{32'h0, 32'h00000077, 32'h0};
      logic [31:0] exps [3] = '{32'hBEEF33AA, 32'h0, 32'hBE7733AA};
      int acc_cyc [3];
      logic [31:0] rsps [3];
      int idx = 0, nrsp = 0, wc = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (mem_wnr) wc++;
         if (rsp_valid) begin
            if (nrsp < 3) rsps[nrsp] = rsp_rdata;
            nrsp++;
         end
         if (req_ready) begin
            if (idx < 3) begin
               req_op = ops[idx]; req_addr = adrs[idx]; req_wdata = wds[idx]; req_valid = 1'b1;
               acc_cyc[idx] = cyc; idx++;
            end else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      total++; if (idx !== 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", idx); end
      total++; if (nrsp !== 3) begin bad++; $display("FAIL b2b_responses got=%0d exp=3", nrsp); end
      total++; if (wc !== 1) begin bad++; $display("FAIL b2b_write_cycles got=%0d exp=1", wc); end
      total++; if (acc_cyc[1] - acc_cyc[0] !== 3) begin bad++; $display("FAIL b2b_gap_lw got=%0d exp=3", acc_cyc[1] - acc_cyc[0]); end
      total++; if (acc_cyc[2] - acc_cyc[1] !== 4) begin bad++; $display("FAIL b2b_gap_sb got=%0d exp=4", acc_cyc[2] - acc_cyc[1]); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rsps[i] !== exps[i]) begin bad++; $display("FAIL b2b_rsp[%0d] got=%h exp=%h", i, rsps[i], exps[i]); end
      end
   endtask

   task automatic test_reset_mid_rmw();
      int seen_rsp = 0, seen_wr = 0;
      @(negedge clk);
      req_op = 3'd5; req_addr = 10'h013; req_wdata = 32'h000000EE; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      if (mem_wnr) seen_wr++;
      if (rsp_valid) seen_rsp++;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmw_rst_ready got=%b exp=1", req_ready); end
      for (int i = 0; i < 5; i++) begin
         if (mem_wnr) seen_wr++;
         if (rsp_valid) seen_rsp++;
         @(negedge clk);
      end
      total++; if (seen_wr !== 0) begin bad++; $display("FAIL rmw_rst_writes got=%0d exp=0", seen_wr); end
      total++; if (seen_rsp !== 0) begin bad++; $display("FAIL rmw_rst_rsp got=%0d exp=0", seen_rsp); end
      total++; if (mem[4] !== 32'hBE7733AA) begin bad++; $display("FAIL rmw_rst_mem got=%h exp=be7733aa", mem[4]); end
   endtask

   task automatic test_misaligned();
      int lat, wc; logic [31:0] rd; logic er;
      issue(3'd2, 10'h011, 32'h0, lat, rd, er, wc);
`ifdef LSU_ALIGN_CHECK_EN
      total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_lw_err got=%b exp=1", er); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_lw_rdata got=%h exp=0", rd); end
      total++; if (lat !== 1) begin bad++; $display("FAIL mis_lw_latency got=%0d exp=1", lat); end
      total++; if (wc !== 0) begin bad++; $display("FAIL mis_lw_writes got=%0d exp=0", wc); end
      issue(3'd7, 10'h012, 32'h01020304, lat, rd, er, wc);
      total++; if (er !== 1'b1 || wc !== 0) begin bad++; $display("FAIL mis_sw got err=%b wr=%0d exp err=1 wr=0", er, wc); end
      total++; if (mem[4] !== 32'hBE7733AA) begin bad++; $display("FAIL mis_sw_mem got=%h exp=be7733aa", mem[4]); end
`else
      total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_lw_err got=%b exp=0", er); end
      total++; if (rd !== 32'hBE7733AA) begin bad++; $display("FAIL mis_lw_rdata got=%h exp=be7733aa", rd); end
      total++; if (lat !== 2) begin bad++; $display("FAIL mis_lw_latency got=%0d exp=2", lat); end
      issue(3'd1, 10'h011, 32'h0, lat, rd, er, wc);
      total++; if (rd !== 32'hFFFFBE77 || er !== 1'b0) begin bad++; $display("FAIL mis_lh got=%h err=%b exp=ffffbe77 err=0", rd, er); end
`endif
   endtask

   initial begin
      test_reset();
      test_lw_round_trip();
      test_load_ext();
      test_rmw();
      test_back_to_back();
      test_reset_mid_rmw();
      test_misaligned();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
